sp_result_pipe: RTL

// Latency pipeline downstream of the combinational single-precision FMA/FM datapath
// in the SP (even-pipe) unit. Captures the 128-bit 4-lane result plus its target

---
 rtl/sp_result_pipe.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sp_result_pipe.sv
// ----------------------------------------------------------------------------
// sp_result_pipe
//
// Latency pipeline behind the combinational single-precision FMA/FM datapath of
// the SP (even-pipe) unit. Each issued op carries its 128-bit, 4-lane result
// and its target register through LATENCY stages (S1..S_LATENCY). The last
// stage drives a one-cycle writeback strobe. The issue logic gets an RT-busy
// scoreboard query and a flush that kills every op still short of writeback.
//
// Optional feature macro: SP_RESULT_FWD_EN
//   defined   : fwd_hit/fwd_data report the youngest valid S1..S_LATENCY entry
//               whose rt matches q_rt (a same-cycle writeback can be forwarded).
//   undefined : fwd_hit and fwd_data are tied to 0 and no match muxes are built.
//
// Parameters
//   LATENCY  stages from issue to writeback (legal 2..8)
//   RT_W     target register address width
//   DATA_W   result width, big-endian bit order [0:DATA_W-1]
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   in_valid      issue strobe; in_rt/in_result valid this cycle
//   in_rt         target register of the issued op
//   in_result     combinational SP datapath output
//   flush         kill all ops not yet in the writeback stage
//   q_rt          scoreboard query address
//   q_busy        q_rt pending in S1..S(LATENCY-1)
//   q_dist        cycles until that pending write lands; 0 when !q_busy
//   wb_valid      writeback strobe (valid of S_LATENCY)
//   wb_rt         writeback register address (holds when wb_valid is low)
//   wb_data       writeback data (holds when wb_valid is low)
//   inflight_cnt  number of valid entries in S1..S_LATENCY
//   fwd_hit       forwarding hit for q_rt
//   fwd_data      forwarded data
// ----------------------------------------------------------------------------
module sp_result_pipe #(
    parameter int unsigned LATENCY = 6,
    parameter int unsigned RT_W    = 7,
    parameter int unsigned DATA_W  = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [RT_W-1:0]   in_rt,
    input  logic [0:DATA_W-1] in_result,
    input  logic              flush,
    input  logic [RT_W-1:0]   q_rt,
    output logic              q_busy,
    output logic [3:0]        q_dist,
    output logic              wb_valid,
    output logic [RT_W-1:0]   wb_rt,
    output logic [0:DATA_W-1] wb_data,
    output logic [3:0]        inflight_cnt,
    output logic              fwd_hit,
    output logic [0:DATA_W-1] fwd_data
);

    // Stage k lives at index k; index LATENCY is the writeback stage.
    logic [LATENCY:1]  valid_q;
    logic [LATENCY:1]  valid_d;
    logic [RT_W-1:0]   rt_q   [1:LATENCY];
    logic [0:DATA_W-1] data_q [1:LATENCY];
    logic [3:0]        cnt_q;
    logic [3:0]        cnt_d;

    // ------------------------------------------------------------------------
    // Next-state valids. Flush clears every stage at once: the entry currently
    // on wb_* has already been presented, so it is not lost, while everything
    // younger (and the op issued this cycle) is dropped.
    // ------------------------------------------------------------------------
    always_comb begin
        valid_d = '0;
        if (!flush) begin
            valid_d[1] = in_valid;
            for (int k = 2; k <= int'(LATENCY); k++) begin
                valid_d[k] = valid_q[k-1];
            end
        end
    end

    // Registered occupancy: popcount of the valids about to be loaded.
    always_comb begin
        cnt_d = '0;
        for (int k = 1; k <= int'(LATENCY); k++) begin
            cnt_d = cnt_d + 4'(valid_d[k]);
        end
    end

    // ------------------------------------------------------------------------
    // Stage registers. rt/data only move when a live entry moves into a stage,
    // so an empty writeback stage keeps showing the last written rt/data.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            cnt_q   <= '0;
            for (int k = 1; k <= int'(LATENCY); k++) begin
                rt_q[k]   <= '0;
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            if (valid_d[1]) begin
                rt_q[1]   <= in_rt;
                data_q[1] <= in_result;
            end
            for (int k = 2; k <= int'(LATENCY); k++) begin
                if (valid_d[k]) begin
                    rt_q[k]   <= rt_q[k-1];
                    data_q[k] <= data_q[k-1];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Scoreboard query over S1..S(LATENCY-1). Scanning oldest to youngest lets
    // the youngest match (smallest k) win. The op issued this cycle is not
    // visible here; the issue logic tracks that itself.
    // ------------------------------------------------------------------------
    always_comb begin
        q_busy = 1'b0;
        q_dist = '0;
        for (int k = int'(LATENCY) - 1; k >= 1; k--) begin
            if (valid_q[k] && (rt_q[k] == q_rt)) begin
                q_busy = 1'b1;
                q_dist = 4'(int'(LATENCY) - k);
            end
        end
    end

`ifdef SP_RESULT_FWD_EN
    // Forwarding includes the writeback stage; youngest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = int'(LATENCY); k >= 1; k--) begin
            if (valid_q[k] && (rt_q[k] == q_rt)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[k];
            end
        end
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    assign wb_valid     = valid_q[LATENCY];
    assign wb_rt        = rt_q[LATENCY];
    assign wb_data      = data_q[LATENCY];
    assign inflight_cnt = cnt_q;

endmodule
